// File: rtl/hash_resp_fifo.sv
// hash_resp_fifo
//
// Response buffer between the hash table's packed response output and the
// host-side consumer. Words of {key_already_present, no_element_found,
// no_write_space, no_deletion_target, read_data} are accepted on a ready/valid
// handshake into a DEPTH-entry FIFO. Saturating counters track clean and
// flagged responses.
//
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous active-low reset
//   resp_i     packed response from the table
//   valid_i    resp_i valid
//   ready_o    FIFO can accept (no combinational path from ready_i)
//   data_o     head entry, same packing as resp_i
//   valid_o    head entry valid
//   ready_i    consumer accepts head
//   fill_o     current occupancy, 0..DEPTH
//   cnt_ok_o   accepted responses with all flags clear
//   cnt_err_o  accepted responses with any flag set
//   clear_i    synchronous clear of both counters (wins over counting)

module hash_resp_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_WIDTH+3:0]      resp_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [DATA_WIDTH+3:0]      data_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH):0]     fill_o,
    output logic [CNT_WIDTH-1:0]       cnt_ok_o,
    output logic [CNT_WIDTH-1:0]       cnt_err_o,
    input  logic                       clear_i
);

    localparam int unsigned W  = DATA_WIDTH + 4;
    localparam int unsigned PW = $clog2(DEPTH);

    localparam logic [PW:0]          FullCount = DEPTH[PW:0];
    localparam logic [PW:0]          CountOne  = 1;
    localparam logic [PW-1:0]        PtrOne    = 1;
    localparam logic [CNT_WIDTH-1:0] CntOne    = 1;

    logic [W-1:0]         mem [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW:0]          count_q, count_d;
    logic [CNT_WIDTH-1:0] cnt_ok_q, cnt_ok_d;
    logic [CNT_WIDTH-1:0] cnt_err_q, cnt_err_d;

    logic push;
    logic pop;
    logic flagged;

    // ready_o looks only at registered occupancy: a pop while full does not
    // open the FIFO until the following cycle.
    assign ready_o = (count_q != FullCount) && reset;
    assign valid_o = (count_q != '0);
    assign data_o  = mem[rd_ptr_q];
    assign fill_o  = count_q;
    assign cnt_ok_o  = cnt_ok_q;
    assign cnt_err_o = cnt_err_q;

    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;
    assign flagged = |resp_i[W-1:DATA_WIDTH];

    always_comb begin
        // DEPTH is a power of two, so pointers wrap by natural overflow.
        wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrOne : rd_ptr_q;

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CountOne;
            2'b01:   count_d = count_q - CountOne;
            default: count_d = count_q;
        endcase

        cnt_ok_d  = cnt_ok_q;
        cnt_err_d = cnt_err_q;
        if (clear_i) begin
            cnt_ok_d  = '0;
            cnt_err_d = '0;
        end else if (push) begin
            if (flagged) begin
                if (!(&cnt_err_q)) cnt_err_d = cnt_err_q + CntOne;
            end else begin
                if (!(&cnt_ok_q)) cnt_ok_d = cnt_ok_q + CntOne;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            cnt_ok_q  <= '0;
            cnt_err_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            cnt_ok_q  <= cnt_ok_d;
            cnt_err_q <= cnt_err_d;
        end
    end

    // Storage is not reset; its contents are unobservable while count is 0.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= resp_i;
    end

endmodule

// File: tb/tb_hash_resp_fifo.sv
module tb_hash_resp_fifo;

    localparam int DW = 32;
    localparam int W  = DW + 4;
    localparam int D  = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;

    // Main instance (CNT_WIDTH=16)
    logic [W-1:0] resp = '0;
    logic         vin = 1'b0;
    logic         rdy_out;
    logic [W-1:0] dout;
    logic         vout;
    logic         rin = 1'b0;
    logic [2:0]   fill;
    logic [15:0]  cok, cerr;
    logic         clr = 1'b0;

    // Saturation instance (CNT_WIDTH=2)
    logic [W-1:0] b_resp = '0;
    logic         b_vin = 1'b0;
    logic         b_rdy_out;
    logic [W-1:0] b_dout;
    logic         b_vout;
    logic         b_rin = 1'b1;
    logic [2:0]   b_fill;
    logic [1:0]   b_cok, b_cerr;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] sb[$];
    int           m_ok = 0;
    int           m_err = 0;

    always #5 clk = ~clk;

    hash_resp_fifo #(.DATA_WIDTH(DW), .DEPTH(D), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .resp_i(resp), .valid_i(vin), .ready_o(rdy_out),
        .data_o(dout), .valid_o(vout), .ready_i(rin), .fill_o(fill),
        .cnt_ok_o(cok), .cnt_err_o(cerr), .clear_i(clr)
    );

    hash_resp_fifo #(.DATA_WIDTH(DW), .DEPTH(D), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset(reset), .resp_i(b_resp), .valid_i(b_vin), .ready_o(b_rdy_out),
        .data_o(b_dout), .valid_o(b_vout), .ready_i(b_rin), .fill_o(b_fill),
        .cnt_ok_o(b_cok), .cnt_err_o(b_cerr), .clear_i(1'b0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge. Drives inputs, checks all outputs against
    // the scoreboard model before the next edge, then advances the model.
    task automatic cycle(input logic v, input logic r, input logic [W-1:0] d, input logic c);
        logic acc, pp;
        vin = v; rin = r; resp = d; clr = c;
        #2;
        chk("ready_o", rdy_out, sb.size() != D);
        chk("valid_o", vout, sb.size() != 0);
        if (sb.size() != 0) chk("data_o", dout, sb[0]);
        chk("fill_o", fill, sb.size());
        chk("cnt_ok_o", cok, m_ok);
        chk("cnt_err_o", cerr, m_err);
        acc = v && (sb.size() != D);
        pp  = r && (sb.size() != 0);
        if (pp) void'(sb.pop_front());
        if (acc) sb.push_back(d);
        if (c) begin
            m_ok = 0; m_err = 0;
        end else if (acc) begin
            if (|d[W-1:DW]) m_err++; else m_ok++;
        end
        @(posedge clk); #1;
        vin = 1'b0; rin = 1'b0; clr = 1'b0;
    endtask

    typedef struct {
        logic         v;
        logic         r;
        logic         c;
        logic [W-1:0] d;
        int           e_fill;
        int           e_ok;
        int           e_err;
    } vec_t;

    vec_t vecs[8];
    int   sat_exp[5];
    logic [W-1:0] w;

    initial begin
        // Flag-counting vectors: expected values after the edge.
        vecs[0] = '{1'b0, 1'b1, 1'b1, 36'h0_00000000, 0, 0, 0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 36'h4_00000011, 1, 0, 1};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 36'h4_00000022, 1, 0, 2};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 36'h4_00000033, 1, 0, 3};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 36'h0_00000044, 1, 1, 3};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 36'h0_00000055, 1, 2, 3};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 36'h4_00000066, 2, 0, 0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 36'h8_00000077, 3, 0, 1};
        sat_exp = '{1, 2, 3, 3, 3};

        // Reset state
        #3;
        chk("rst valid_o", vout, 0);
        chk("rst fill_o", fill, 0);
        chk("rst ready_o", rdy_out, 0);
        chk("rst cnt_ok", cok, 0);
        chk("rst cnt_err", cerr, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        #2;
        chk("ready after release", rdy_out, 1);
        @(posedge clk); #1;

        // Single push, then observe and drain
        cycle(1'b1, 1'b0, 36'h0_DEADBEEF, 1'b0);
        chk("single data_o", dout, 36'h0_DEADBEEF);
        chk("single cnt_ok", cok, 1);
        chk("single cnt_err", cerr, 0);
        cycle(1'b0, 1'b1, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);

        // Fill to full, reject 5th, drain in order
        for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, W'(i), 1'b0);
        cycle(1'b1, 1'b0, 36'd5, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            chk("drain order", dout, i);
            cycle(1'b0, 1'b1, '0, 1'b0);
        end
        cycle(1'b0, 1'b0, '0, 1'b0);

        // Full with simultaneous pop: push must not be taken that cycle
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, W'(36'h100 + i), 1'b0);
        cycle(1'b1, 1'b1, 36'h1FF, 1'b0);
        chk("full pop no push fill", fill, 3);
        cycle(1'b1, 1'b0, 36'h200, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);

        // Streaming across pointer wrap
        cycle(1'b1, 1'b0, 36'h0_A0000000, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 1'b1, W'(36'h0_A0000000 + i), 1'b0);
            chk("stream fill", fill, 1);
        end
        cycle(1'b0, 1'b1, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);

        // Flag counting and clear priority
        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].v, vecs[i].r, vecs[i].d, vecs[i].c);
            chk($sformatf("vec%0d fill", i), fill, vecs[i].e_fill);
            chk($sformatf("vec%0d cnt_ok", i), cok, vecs[i].e_ok);
            chk($sformatf("vec%0d cnt_err", i), cerr, vecs[i].e_err);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);

        // Saturation on the 2-bit counter instance
        for (int i = 0; i < 5; i++) begin
            b_vin = 1'b1; b_resp = W'(i + 1);
            @(posedge clk); #1;
            b_vin = 1'b0;
            chk($sformatf("sat cnt_ok %0d", i), b_cok, sat_exp[i]);
        end
        chk("sat cnt_err", b_cerr, 0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, W'(36'h0_C0 + i), 1'b0);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst valid_o", vout, 0);
        chk("midrst fill_o", fill, 0);
        chk("midrst ready_o", rdy_out, 0);
        chk("midrst cnt_ok", cok, 0);
        chk("midrst cnt_err", cerr, 0);
        chk("midrst sat cnt_ok", b_cok, 0);
        sb.delete(); m_ok = 0; m_err = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        #2;
        chk("ready after midrst", rdy_out, 1);
        @(posedge clk); #1;
        w = 36'h0_12345678;
        cycle(1'b1, 1'b0, w, 1'b0);
        chk("first out after reset", dout, w);
        cycle(1'b0, 1'b1, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
